fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 40 ++++
 rtl/fetch_len_dec.sv | 26 ++
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch stage: datapath width, instruction codes,
// instruction lengths, status codes and controller states.
package fetch_ctrl_pkg;

  localparam int unsigned DATA_WID = 32;

  typedef enum logic [3:0] {
    IHalt   = 4'h0,
    INop    = 4'h1,
    IRrmovl = 4'h2,
    IIrmovl = 4'h3,
    IRmmovl = 4'h4,
    IMrmovl = 4'h5,
    IOpl    = 4'h6,
    IJxx    = 4'h7,
    ICall   = 4'h8,
    IRet    = 4'h9,
    IPushl  = 4'hA,
    IPopl   = 4'hB
  } icode_e;

  localparam logic [2:0] Len1 = 3'd1;
  localparam logic [2:0] Len2 = 3'd2;
  localparam logic [2:0] Len5 = 3'd5;
  localparam logic [2:0] Len6 = 3'd6;

  typedef enum logic [1:0] {
    StatAok = 2'b00,
    StatHlt = 2'b01,
    StatIns = 2'b10
  } stat_e;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt,
    StErr
  } state_e;

endpackage

// File: rtl/fetch_len_dec.sv
// Combinational instruction length and validity decode from icode.
module fetch_len_dec
  import fetch_ctrl_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [2:0] len_o,
  output logic       invalid_o
);

  always_comb begin
    len_o     = Len1;
    invalid_o = 1'b0;
    unique case (icode_i)
      IHalt, INop, IRet:              len_o = Len1;
      IRrmovl, IOpl, IPushl, IPopl:   len_o = Len2;
      IJxx, ICall:                    len_o = Len5;
      IIrmovl, IRmmovl, IMrmovl:      len_o = Len6;
      // Invalid codes still advance by one so out_valP stays well defined.
      default: begin
        len_o     = Len1;
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: walks the PC through a combinational instruction memory and
// holds one fetched instruction for decode under a valid/ready handshake.
module fetch_ctrl #(
  parameter int unsigned DATA_WID = fetch_ctrl_pkg::DATA_WID
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_WID-1:0] start_pc,
  output logic [DATA_WID-1:0] imem_pc,
  input  logic [3:0]          imem_icode,
  input  logic [3:0]          imem_ifun,
  input  logic [3:0]          imem_rA,
  input  logic [3:0]          imem_rB,
  input  logic [DATA_WID-1:0] imem_valC,
  input  logic                redirect_valid,
  input  logic [DATA_WID-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_icode,
  output logic [3:0]          out_ifun,
  output logic [3:0]          out_rA,
  output logic [3:0]          out_rB,
  output logic [DATA_WID-1:0] out_valC,
  output logic [DATA_WID-1:0] out_valP,
  output logic [DATA_WID-1:0] out_pc,
  output logic [1:0]          stat
);

  import fetch_ctrl_pkg::*;

  state_e              state_q, state_d;
  stat_e               stat_q, stat_d;
  logic [DATA_WID-1:0] pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [3:0]          icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_WID-1:0] valc_q, valc_d, valp_q, valp_d, opc_q, opc_d;

  logic [2:0]          len;
  logic                invalid;
  logic [DATA_WID-1:0] pc_next;

  fetch_len_dec u_len_dec (
    .icode_i   (imem_icode),
    .len_o     (len),
    .invalid_o (invalid)
  );

  assign pc_next = pc_q + DATA_WID'(len);

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    opc_d   = opc_q;

    // Acceptance drains the held slot; a capture below refills it.
    if (out_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (!valid_q || out_ready) begin
          valid_d = 1'b1;
          icode_d = imem_icode;
          ifun_d  = imem_ifun;
          ra_d    = imem_rA;
          rb_d    = imem_rB;
          valc_d  = imem_valC;
          valp_d  = pc_next;
          opc_d   = pc_q;
          pc_d    = pc_next;
          if (invalid) begin
            stat_d  = StatIns;
            state_d = StErr;
          end else if (imem_icode == IHalt) begin
            stat_d  = StatHlt;
            state_d = StHalt;
          end
        end
      end
      StHalt, StErr: begin
        if (start) begin
          pc_d    = start_pc;
          stat_d  = StatAok;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stat_q  <= StatAok;
      pc_q    <= '0;
      valid_q <= 1'b0;
      icode_q <= '0;
      ifun_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      valc_q  <= '0;
      valp_q  <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      opc_q   <= opc_d;
    end
  end

  assign imem_pc   = pc_q;
  assign out_valid = valid_q;
  assign out_icode = icode_q;
  assign out_ifun  = ifun_q;
  assign out_rA    = ra_q;
  assign out_rB    = rb_q;
  assign out_valC  = valc_q;
  assign out_valP  = valp_q;
  assign out_pc    = opc_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized program checked
// against an instruction-stream model built from the length table.
module tb_fetch_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, redirect_valid, out_ready;
  logic [W-1:0] start_pc, redirect_pc;
  logic [W-1:0] imem_pc, imem_valC;
  logic [3:0]   imem_icode, imem_ifun, imem_rA, imem_rB;
  logic         out_valid;
  logic [3:0]   out_icode, out_ifun, out_rA, out_rB;
  logic [W-1:0] out_valC, out_valP, out_pc;
  logic [1:0]   stat;

  logic [3:0]   mem_icode [1024];
  logic [3:0]   mem_ifun  [1024];
  logic [3:0]   mem_ra    [1024];
  logic [3:0]   mem_rb    [1024];
  logic [W-1:0] mem_valc  [1024];

  assign imem_icode = mem_icode[imem_pc[9:0]];
  assign imem_ifun  = mem_ifun[imem_pc[9:0]];
  assign imem_rA    = mem_ra[imem_pc[9:0]];
  assign imem_rB    = mem_rb[imem_pc[9:0]];
  assign imem_valC  = mem_valc[imem_pc[9:0]];

  always #5 clk = ~clk;

  fetch_ctrl #(.DATA_WID(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .imem_pc        (imem_pc),
    .imem_icode     (imem_icode),
    .imem_ifun      (imem_ifun),
    .imem_rA        (imem_rA),
    .imem_rB        (imem_rB),
    .imem_valC      (imem_valC),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_icode      (out_icode),
    .out_ifun       (out_ifun),
    .out_rA         (out_rA),
    .out_rB         (out_rB),
    .out_valC       (out_valC),
    .out_valP       (out_valP),
    .out_pc         (out_pc),
    .stat           (stat)
  );

  typedef struct {
    logic [3:0]   icode, ifun, ra, rb;
    logic [W-1:0] valc, valp, pc;
  } instr_t;

  instr_t q[$];
  int     tests = 0;
  int     fails = 0;

  localparam logic [1:0] AOK = 2'b00, HLT = 2'b01, INS = 2'b10;

  function automatic int unsigned ilen(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 5;
      default:                return 6;
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] a, input logic [3:0] ic, input logic [W-1:0] vc);
    mem_icode[a[9:0]] = ic;
    mem_ifun[a[9:0]]  = 4'(a[3:0]);
    mem_ra[a[9:0]]    = 4'h3;
    mem_rb[a[9:0]]    = 4'h5;
    mem_valc[a[9:0]]  = vc;
  endtask

  task automatic go(input logic [W-1:0] a);
    start    = 1'b1;
    start_pc = a;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    logic [W-1:0] p;
    instr_t       e;
    for (int i = 0; i < 1024; i++) put(W'(i), 4'h0, '0);
    rst = 1'b1; start = 1'b0; start_pc = '0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_stat", stat, AOK);
    check("rst_pc", imem_pc, 0);
    tick();
    check("idle_no_fetch", imem_pc, 0);

    // nop, irmovl, addl, halt back-to-back
    put(32'h100, 4'h1, '0);
    put(32'h101, 4'h3, 32'h1234);
    put(32'h107, 4'h6, '0);
    put(32'h109, 4'h0, '0);
    go(32'h100);
    check("seq_first_pc", imem_pc, 32'h100);
    check("seq_first_valid", out_valid, 1'b0);
    tick();
    check("seq0", {out_valid, out_icode, out_pc, out_valP}, {1'b1, 4'h1, 32'h100, 32'h101});
    tick();
    check("seq1", {out_icode, out_pc, out_valP, out_valC}, {4'h3, 32'h101, 32'h107, 32'h1234});
    tick();
    check("seq2", {out_icode, out_pc, out_valP}, {4'h6, 32'h107, 32'h109});
    tick();
    check("seq_halt", {out_valid, out_icode, stat, imem_pc}, {1'b1, 4'h0, HLT, 32'h10A});
    tick();
    check("seq_drain", out_valid, 1'b0);

    // stall with ready low
    put(32'h200, 4'h1, '0);
    put(32'h201, 4'h3, 32'h55);
    put(32'h207, 4'h1, '0);
    put(32'h208, 4'h0, '0);
    out_ready = 1'b0;
    go(32'h200);
    check("restart_stat", {stat, imem_pc}, {AOK, 32'h200});
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", {out_valid, out_icode, out_pc, out_valP, imem_pc},
            {1'b1, 4'h1, 32'h200, 32'h201, 32'h201});
    end
    out_ready = 1'b1;
    tick();
    check("stall_release", {out_icode, out_pc, out_valP, out_valC}, {4'h3, 32'h201, 32'h207, 32'h55});
    tick(); tick();
    check("stall_halt", stat, HLT);
    tick();

    // redirect flushes the held jXX
    put(32'h20, 4'h7, 32'h80);
    put(32'h80, 4'h1, '0);
    put(32'h81, 4'h0, '0);
    out_ready = 1'b0;
    go(32'h20);
    tick();
    check("jxx_held", {out_valid, out_icode, out_pc, out_valP}, {1'b1, 4'h7, 32'h20, 32'h25});
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush", {out_valid, imem_pc}, {1'b0, 32'h80});
    out_ready = 1'b1;
    tick();
    check("redir_target", {out_valid, out_icode, out_pc}, {1'b1, 4'h1, 32'h80});
    tick(); tick();

    // halt freezes pc; redirect ignored; start beats redirect
    put(32'h30, 4'h0, '0);
    put(32'h0, 4'h1, '0);
    put(32'h1, 4'h0, '0);
    go(32'h30);
    tick();
    check("halt", {out_icode, out_pc, stat, imem_pc}, {4'h0, 32'h30, HLT, 32'h31});
    redirect_valid = 1'b1; redirect_pc = 32'h55;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("halt_frozen", {out_valid, stat, imem_pc}, {1'b0, HLT, 32'h31});
    redirect_valid = 1'b1; redirect_pc = 32'h3F0;
    go(32'h0);
    redirect_valid = 1'b0;
    check("start_wins", {stat, imem_pc}, {AOK, 32'h0});
    tick();
    check("from_zero", {out_valid, out_icode, out_pc}, {1'b1, 4'h1, 32'h0});
    tick(); tick();

    // invalid icode
    put(32'h40, 4'hE, '0);
    out_ready = 1'b0;
    go(32'h40);
    tick();
    check("ins", {out_valid, out_icode, out_pc, stat}, {1'b1, 4'hE, 32'h40, INS});
    redirect_valid = 1'b1; redirect_pc = 32'h90;
    tick();
    redirect_valid = 1'b0;
    check("ins_redir_ign", {out_valid, out_pc, stat, imem_pc == 32'h90}, {1'b1, 32'h40, INS, 1'b0});
    out_ready = 1'b1;
    tick();
    check("ins_drain", {out_valid, stat}, {1'b0, INS});

    // reset during stall overrides start and redirect
    out_ready = 1'b0;
    go(32'h200);
    check("err_restart", stat, AOK);
    tick(); tick();
    rst = 1'b1; start = 1'b1; start_pc = 32'h100; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    rst = 1'b0; start = 1'b0; redirect_valid = 1'b0;
    check("mid_rst", {out_valid, stat, imem_pc, out_pc, out_icode, out_valP},
          {1'b0, AOK, 32'h0, 32'h0, 4'h0, 32'h0});
    out_ready = 1'b1;
    tick(); tick();
    check("rst_needs_start", {out_valid, imem_pc}, {1'b0, 32'h0});

    // randomized program, random back-pressure
    p = 32'h300;
    for (int i = 0; i < 40; i++) begin
      e.icode = 4'($urandom_range(1, 11));
      e.ifun  = 4'($urandom);
      e.ra    = 4'($urandom);
      e.rb    = 4'($urandom);
      e.valc  = W'($urandom);
      e.pc    = p;
      e.valp  = p + W'(ilen(e.icode));
      mem_icode[p[9:0]] = e.icode;
      mem_ifun[p[9:0]]  = e.ifun;
      mem_ra[p[9:0]]    = e.ra;
      mem_rb[p[9:0]]    = e.rb;
      mem_valc[p[9:0]]  = e.valc;
      q.push_back(e);
      p = e.valp;
    end
    put(p, 4'h0, '0);
    e.icode = 4'h0; e.ifun = mem_ifun[p[9:0]]; e.ra = 4'h3; e.rb = 4'h5;
    e.valc = '0; e.pc = p; e.valp = p + 1;
    q.push_back(e);

    out_ready = 1'b0;
    go(32'h300);
    for (int c = 0; c < 600 && q.size() > 0; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid) begin
        check("rand_instr",
              {out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_pc},
              {q[0].icode, q[0].ifun, q[0].ra, q[0].rb, q[0].valc, q[0].valp, q[0].pc});
        if (out_ready) void'(q.pop_front());
      end
      tick();
    end
    check("rand_drain", q.size(), 0);
    check("rand_stat", {out_valid, stat}, {1'b0, HLT});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
